// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
// Bundles the receive-byte handshake, the CSR pop/status path and the
// interrupt line of the UART receive FIFO.
//   master : receiver + CSR side (drives rx_*, rd_en, thresh, ovf_clr)
//   slave  : FIFO side (drives rd_data, rd_err, empty, full, count,
//            overflow, irq_o)
// ADDR_W must match the ADDR_W of the attached uart_rx_fifo.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_frame_err;
  logic            rd_en;
  logic [ADDR_W:0] thresh;
  logic            ovf_clr;
  logic [7:0]      rd_data;
  logic            rd_err;
  logic            empty;
  logic            full;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            irq_o;

  modport master (
    output rx_data, rx_valid, rx_frame_err, rd_en, thresh, ovf_clr,
    input  rd_data, rd_err, empty, full, count, overflow, irq_o
  );

  modport slave (
    input  rx_data, rx_valid, rx_frame_err, rd_en, thresh, ovf_clr,
    output rd_data, rd_err, empty, full, count, overflow, irq_o
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer between the UART receiver and the Wishbone CSR
// logic. Each completed byte is stored with its frame-error flag in a
// DEPTH-entry first-word-fall-through FIFO; the head entry is presented
// combinationally to the CSR read path. A registered level interrupt fires
// when occupancy reaches a programmable threshold and, optionally, when
// buffered data has sat idle for TIMEOUT_CYCLES.
//
// Ports:
//   wb_clk_i  sole clock
//   wb_rst_i  synchronous active-high reset
//   bus       uart_rx_fifo_if.slave: rx_data/rx_valid/rx_frame_err in,
//             rd_en/thresh/ovf_clr in, rd_data/rd_err/empty/full/count/
//             overflow/irq_o out
//
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build the character
// idle timeout. Without it irq_o is driven by the threshold only.
module uart_rx_fifo #(
  parameter int          DEPTH          = 16,
  parameter int          ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 166667
) (
  input logic           wb_clk_i,
  input logic           wb_rst_i,
  uart_rx_fifo_if.slave bus
);

  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  // Reject configurations the pointer/count arithmetic cannot represent.
  if (DEPTH != (1 << ADDR_W) || DEPTH < 4 || DEPTH > 256 || TIMEOUT_CYCLES == 0)
  begin : g_cfg_check
    $error("uart_rx_fifo: inconsistent DEPTH/ADDR_W/TIMEOUT_CYCLES");
  end

  logic [8:0]        mem [DEPTH];
  logic [8:0]        head;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_next;
  logic              empty_r;
  logic              full_r;
  logic              overflow_r;
  logic              thresh_hit_r;
  logic              irq_r;
  logic              push;
  logic              pop;
  logic              drop;
  logic              thresh_hit;
  logic              timeout_flag;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  // the byte. A pop while empty is ignored even if a push lands alongside.
  always_comb begin
    push       = bus.rx_valid && (!full_r || bus.rd_en);
    pop        = bus.rd_en && !empty_r;
    drop       = bus.rx_valid && full_r && !bus.rd_en;
    count_next = count_r;
    case ({push, pop})
      2'b10:   count_next = count_r + CNT_ONE;
      2'b01:   count_next = count_r - CNT_ONE;
      default: count_next = count_r;
    endcase
    thresh_hit = (bus.thresh != '0) && (count_next >= bus.thresh);
  end

  // Storage is not reset; reads of stale entries are masked by empty.
  always_ff @(posedge wb_clk_i) begin
    if (push && !wb_rst_i) begin
      mem[wptr] <= {bus.rx_frame_err, bus.rx_data};
    end
  end

  // thresh_hit is staged once more before irq_o so the interrupt follows
  // the count change by one cycle. Drop beats ovf_clr when both occur.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wptr         <= '0;
      rptr         <= '0;
      count_r      <= '0;
      empty_r      <= 1'b1;
      full_r       <= 1'b0;
      overflow_r   <= 1'b0;
      thresh_hit_r <= 1'b0;
      irq_r        <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      count_r      <= count_next;
      empty_r      <= (count_next == '0);
      full_r       <= (count_next == DEPTH_CNT);
      if (drop) begin
        overflow_r <= 1'b1;
      end else if (bus.ovf_clr) begin
        overflow_r <= 1'b0;
      end
      thresh_hit_r <= thresh_hit;
      irq_r        <= thresh_hit_r | timeout_flag;
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam logic [31:0] TMO_MAX = 32'(TIMEOUT_CYCLES);

  logic [31:0] idle_cnt;

  // Counts cycles with data waiting but no traffic; saturates at the limit
  // so the timeout stays asserted until something moves.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || push || pop || empty_r) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TMO_MAX) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  assign timeout_flag = (idle_cnt == TMO_MAX) && !empty_r;
`else
  assign timeout_flag = 1'b0;
`endif

  assign head         = mem[rptr];
  assign bus.rd_data  = empty_r ? 8'h00 : head[7:0];
  assign bus.rd_err   = empty_r ? 1'b0 : head[8];
  assign bus.empty    = empty_r;
  assign bus.full     = full_r;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
  assign bus.irq_o    = irq_r;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between the UART receiver and the Wishbone control/CSR logic of the user-project UART. It captures each byte the receiver completes, with its frame-error flag, into a DEPTH-entry first-word-fall-through FIFO. It presents the head entry to the CSR read path and raises a level interrupt on fill threshold, plus optional character timeout. This lets firmware drain bursts at 9600 baud without per-byte IRQ servicing.

## Interface
- DEPTH, 16 — entries; power of two, 4..256.
- ADDR_W, 4 — log2(DEPTH); must match DEPTH.
- TIMEOUT_CYCLES, 166667 — idle cycles before timeout IRQ (≈4 char times at 40 MHz / 9600 baud); 1..2^32-1.

- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from receiver.
- rx_valid  in  1  one-cycle pulse: rx_data/rx_frame_err valid.
- rx_frame_err  in  1  stop-bit error for this byte.
- rd_en  in  1  one-cycle pop pulse from CSR logic.
- thresh  in  ADDR_W+1  IRQ fill threshold; 0 disables threshold IRQ.
- ovf_clr  in  1  clears sticky overflow.
- rd_data  out  8  head byte (FWFT); 0 when empty.
- rd_err  out  1  frame-error flag of head entry; 0 when empty.
- empty  out  1  no entries.
- full  out  1  count == DEPTH.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky: byte dropped while full.
- irq_o  out  1  registered level interrupt.

## Operation
- Storage: DEPTH × 9 bits {frame_err, data}. Write pointer and read pointer are ADDR_W bits, wrapping mod DEPTH. count is a separate ADDR_W+1-bit register.
- Push: rx_valid && (!full || rd_en). Writes mem[wptr] and increments wptr.
- Pop: rd_en && !empty. Increments rptr. rd_en while empty is ignored and has no side effects.
- Simultaneous push + pop: both happen and count is unchanged. This includes the full case, where the byte is accepted.
- Empty with rx_valid and rd_en in the same cycle: the push is accepted and the pop is ignored.
- Drop: rx_valid && full && !rd_en. The byte is discarded, overflow is set, and count/pointers are unchanged.
- overflow: set on drop and cleared by ovf_clr. If both occur in the same cycle, set wins.
- Threshold: thresh_hit = (thresh != 0) && (count >= thresh). The comparison uses the next-state count.
- irq_o = thresh_hit | timeout_flag (see Configuration). It is registered.
- empty, full and count are registered, derived from next-state count.

## Timing
- Reset (synchronous, wb_rst_i sampled high at a clock edge) clears:
  - pointers, count, overflow, irq_o and the timeout counter/flag;
  - resulting outputs: empty=1, full=0, count=0, rd_data=0, rd_err=0, overflow=0, irq_o=0.
- Memory contents are not reset.
- Reset mid-burst discards all buffered bytes. An rx_valid in the reset cycle is dropped and does not set overflow.
- Push at edge N: count/empty/full update after edge N, and rd_data shows the byte during cycle N+1 when the FIFO was empty. Latency is 1 cycle.
- Pop at edge N: the next head is on rd_data during cycle N+1. The CSR reads rd_data in the cycle it asserts rd_en.
- irq_o reflects state after edge N at edge N+1 (1 cycle after count changes).
- Back-to-back rx_valid every cycle is supported, although the receiver never issues that.

## Configuration
- UART_RX_FIFO_TIMEOUT_EN defined:
  - a 32-bit idle counter resets to 0 on any push, any pop, or while empty;
  - otherwise it increments each cycle, saturating at TIMEOUT_CYCLES;
  - timeout_flag = (counter == TIMEOUT_CYCLES) && !empty, and contributes to irq_o.
- Not defined: no counter is instantiated, timeout_flag is constant 0, and irq_o = registered thresh_hit only.

## Test plan
- Reset, push 0x41, 0x42, 0x43 (0x42 with frame_err=1):
  - count=3 and empty=0;
  - pops return 0x41/err0, 0x42/err1, 0x43/err0;
  - then empty=1, rd_data=0.
- Fill 16 bytes 0x00..0x0F, then push 0xAA without rd_en:
  - full=1, overflow=1, count=16;
  - pops return 0x00..0x0F, with 0xAA absent;
  - ovf_clr then drives overflow to 0.
- Full FIFO, rx_valid(0x55) with rd_en in the same cycle: count stays 16, and the 16th pop returns 0x55.
- thresh=4: the push making count=4 asserts irq_o one cycle later; the pop to count=3 deasserts it one cycle after. thresh=0 never asserts irq_o.
- With UART_RX_FIFO_TIMEOUT_EN, TIMEOUT_CYCLES=100, thresh=0, one push and idle: irq_o rises 101–102 cycles after the push, and a pop (empty) drops it the next cycle. Without the macro, irq_o stays 0.
- Assert wb_rst_i with 5 bytes buffered: the next cycle shows count=0, empty=1, irq_o=0, overflow=0.
